currctrl_in_cond: RTL and testbench
===================================

CURRCTRL_IN_COND -- requirements
Module: currctrl_in_cond

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of conditioned input bits; equals the width of the downstream GPIO in_port.
REQ-002 SHALL have parameter PRESCALE, default 100: debounce tick period in clk cycles, legal range 2..65535.
REQ-003 SHALL have parameter DB_THRESH, default 8: consecutive disagreeing ticks required to accept a new level, legal range 2..15.
REQ-004 SHALL have parameter LATCH_MASK, default 32'h0000_0000: bit set means the output bit is a sticky latch of rising edges.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port raw_in, input, WIDTH: asynchronous field inputs (coil fault, limit and interlock signals).
REQ-008 SHALL have port clear_in, input, WIDTH: per-bit synchronous clear for latched bits, active high.
REQ-009 SHALL have port cond_out, output, WIDTH: conditioned value that drives the GPIO in_port.
REQ-010 SHALL have port change_pulse, output, 1: one-cycle pulse when any debounced bit changes.

Function
REQ-011 SHALL pass each raw_in bit through a 2-flop synchronizer (sync); sync reflects raw_in 2 clk edges later.
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1 and wrapping to 0; tick SHALL be high for one cycle when count == PRESCALE-1.
REQ-013 Per bit, SHALL hold a debounced state db and a counter cnt (4 bits).
REQ-014 On any cycle where sync[i] == db[i], cnt[i] SHALL be cleared to 0 regardless of tick.
REQ-015 On a tick cycle with sync[i] != db[i] and cnt[i] < DB_THRESH-1, cnt[i] SHALL increment.
REQ-016 On a tick cycle with sync[i] != db[i] and cnt[i] == DB_THRESH-1, db[i] SHALL take sync[i] and cnt[i] SHALL clear.
REQ-017 Non-tick cycles with disagreement SHALL hold cnt; a glitch shorter than one tick that returns before a tick SHALL not be accepted.
REQ-018 For a stable raw_in change, cond_out latency SHALL be 2 cycles plus between (DB_THRESH-1)*PRESCALE+1 and DB_THRESH*PRESCALE cycles.
REQ-019 For a bit with LATCH_MASK[i]=1, latch[i] SHALL set on the cycle db[i] rises 0->1 and clear on clear_in[i]=1.
REQ-020 When a rise and clear_in[i] occur on the same cycle, set SHALL win.
REQ-021 clear_in SHALL have no effect on bits with LATCH_MASK[i]=0.
REQ-022 cond_out[i] SHALL be the registered latch[i] when LATCH_MASK[i]=1, else db[i]; there is no combinational path from raw_in.
REQ-023 change_pulse SHALL be registered and high for exactly one cycle following any cycle in which one or more db bits changed; multiple simultaneous changes give one pulse.

Reset
REQ-024 While reset_n is low: sync, db, cnt, latch, prescaler, cond_out and change_pulse SHALL all be 0.
REQ-025 Reset asserted mid-debounce SHALL discard partial counts; after release, debouncing restarts from db=0 with the prescaler at 0.

Structure
REQ-026 Package currctrl_in_cond_pkg SHALL hold default constants for WIDTH, PRESCALE, DB_THRESH and LATCH_MASK, plus the cnt width constant (4).
REQ-027 Per-bit debounce and latch logic SHALL be sub-module currctrl_in_cond_bit, generated WIDTH times; the prescaler and change_pulse logic stay in the top level.

Verification
Bench parameters: PRESCALE=4, DB_THRESH=3, LATCH_MASK=32'h0000_0001.
REQ-028 Set raw_in[4] 0->1 and hold -> cond_out[4]=1 between 11 and 14 cycles after the edge; change_pulse is high for exactly 1 cycle.
REQ-029 Pulse raw_in[5] high for 3 cycles -> cond_out[5] stays 0 and change_pulse never asserts.
REQ-030 Set raw_in[0] high, hold until cond_out[0]=1, then drop raw_in[0] -> cond_out[0] stays 1; clear_in[0] for 1 cycle -> cond_out[0]=0 on the next cycle.
REQ-031 Assert clear_in[0] on the same cycle db[0] rises -> cond_out[0]=1.
REQ-032 Step raw_in from 32'h0 to 32'hFFFF_FFFE together -> all debounced bits update on the same cycle, with a single change_pulse.
REQ-033 Pull reset_n low for 1 cycle, 8 cycles after a raw_in[7] edge -> cond_out=0 and change_pulse=0; after release, cond_out[7] rises 11..14 cycles after release.

Source files
------------

// File: rtl/currctrl_in_cond_pkg.sv
// Shared defaults and types for the current-controller input conditioning block.
package currctrl_in_cond_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefPrescale  = 100;
  localparam int unsigned DefDbThresh  = 8;
  localparam logic [31:0] DefLatchMask = 32'h0000_0000;

  localparam int unsigned CntWidth = 4;
  // Wide enough for the largest legal prescale period (65535).
  localparam int unsigned PscWidth = 16;

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [PscWidth-1:0] psc_t;

  typedef struct packed {
    logic cond;
    logic changed;
  } bit_out_t;

  function automatic cnt_t thresh_max(int unsigned thresh);
    return cnt_t'(thresh - 1);
  endfunction

endpackage

// File: rtl/currctrl_in_cond_bit.sv
// One conditioned input: 2-flop synchronizer, tick-based debouncer and optional
// sticky rising-edge latch.
module currctrl_in_cond_bit
  import currctrl_in_cond_pkg::*;
#(
  parameter int unsigned DB_THRESH = DefDbThresh,
  parameter bit          LATCH_EN  = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     raw_i,
  input  logic     clear_i,
  input  logic     tick_i,
  output bit_out_t status_o
);

  localparam cnt_t CntMax = thresh_max(DB_THRESH);

  logic sync1_q, sync1_d;
  logic sync_q, sync_d;
  logic db_q, db_d;
  logic latch_q, latch_d;
  cnt_t cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_i;
    sync_d  = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;

    // Agreement restarts the run; disagreement only advances on ticks.
    if (sync_q == db_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q >= CntMax) begin
        db_d  = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end

    // A rise arriving with a clear keeps the latch set.
    if (db_d && !db_q) begin
      latch_d = 1'b1;
    end else if (clear_i) begin
      latch_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      latch_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    status_o.cond    = LATCH_EN ? latch_q : db_q;
    status_o.changed = db_d ^ db_q;
  end

endmodule

// File: rtl/currctrl_in_cond.sv
// Input conditioning for the current controller: shared debounce prescaler,
// per-bit conditioning slices and a single registered change pulse.
module currctrl_in_cond
  import currctrl_in_cond_pkg::*;
#(
  parameter int unsigned      WIDTH      = DefWidth,
  parameter int unsigned      PRESCALE   = DefPrescale,
  parameter int unsigned      DB_THRESH  = DefDbThresh,
  parameter logic [WIDTH-1:0] LATCH_MASK = WIDTH'(DefLatchMask)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clear_in,
  output logic [WIDTH-1:0] cond_out,
  output logic             change_pulse
);

  psc_t             psc_q, psc_d;
  logic             tick;
  logic             pulse_q, pulse_d;
  logic [WIDTH-1:0] db_changed;

  always_comb begin
    tick    = (psc_q == psc_t'(PRESCALE - 1));
    psc_d   = tick ? '0 : psc_q + psc_t'(1);
    // Any number of simultaneous bit changes collapses into one pulse.
    pulse_d = |db_changed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      pulse_q <= pulse_d;
    end
  end

  assign change_pulse = pulse_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    bit_out_t status;

    currctrl_in_cond_bit #(
      .DB_THRESH(DB_THRESH),
      .LATCH_EN (LATCH_MASK[g])
    ) u_bit (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .raw_i   (raw_in[g]),
      .clear_i (clear_in[g]),
      .tick_i  (tick),
      .status_o(status)
    );

    assign cond_out[g]   = status.cond;
    assign db_changed[g] = status.changed;
  end

endmodule

// File: tb/tb_currctrl_in_cond.sv
// Scoreboard bench for currctrl_in_cond: directed scenarios plus random stimulus
// against a cycle-level behavioural model.
module tb_currctrl_in_cond;

  localparam int W = 32;
  localparam int P = 4;
  localparam int T = 3;
  localparam logic [31:0] LM = 32'h0000_0001;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  raw_in;
  logic [W-1:0]  clear_in;
  logic [W-1:0]  cond_out;
  logic          change_pulse;

  currctrl_in_cond #(
    .WIDTH     (W),
    .PRESCALE  (P),
    .DB_THRESH (T),
    .LATCH_MASK(LM)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .clear_in    (clear_in),
    .cond_out    (cond_out),
    .change_pulse(change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, updated once per rising edge.
  typedef struct {
    int unsigned cyc;
    logic [31:0] cout;
  } ev_t;

  ev_t         sb_q[$];
  ev_t         mon_ev;
  int unsigned cyc = 0;
  logic [31:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_latch = '0;
  int          m_cnt[W];
  int          m_pc = 0;
  logic [31:0] exp_cout = '0;

  always @(posedge clk) begin
    logic [31:0] new_db, rises;
    bit tick;
    cyc++;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_latch = '0; m_pc = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      exp_cout = '0;
      sb_q.delete();
    end else begin
      tick   = (m_pc == P - 1);
      new_db = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i]) m_cnt[i] = 0;
        else if (tick) begin
          if (m_cnt[i] == T - 1) begin
            new_db[i] = m_s2[i];
            m_cnt[i]  = 0;
          end else m_cnt[i]++;
        end
      end
      rises   = new_db & ~m_db;
      m_latch = ((m_latch & ~(clear_in & LM)) | (rises & LM)) & LM;
      if (new_db != m_db) sb_q.push_back('{cyc, ((m_latch & LM) | (new_db & ~LM))});
      m_db     = new_db;
      m_s2     = m_s1;
      m_s1     = raw_in;
      m_pc     = (m_pc + 1) % P;
      exp_cout = (m_latch & LM) | (m_db & ~LM);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_cond_out", cond_out, 32'd0);
      chk("reset_change_pulse", {31'd0, change_pulse}, 32'd0);
      sb_q.delete();
    end else begin
      chk("cond_out_vs_model", cond_out, exp_cout);
      if (change_pulse !== 1'b0) begin
        pulse_cnt++;
        if (sb_q.size() == 0) begin
          chk("pulse_unexpected", {31'd0, change_pulse}, 32'd0);
        end else begin
          mon_ev = sb_q.pop_front();
          chk("pulse_cycle", cyc, mon_ev.cyc);
          chk("pulse_cond_out", cond_out, mon_ev.cout);
        end
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick_wait(2);
    reset_n = 1'b1;
  endtask

  function automatic bit will_rise0();
    return (m_pc == P - 1) && m_s2[0] && !m_db[0] && (m_cnt[0] == T - 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, p0, r;
    logic [31:0] first_val;
    bit hit;
    reset_n  = 1'b0;
    raw_in   = '0;
    clear_in = '0;
    tick_wait(2);
    chk("reset_state_cond_out", cond_out, 32'd0);
    reset_n = 1'b1;
    tick_wait(2);

    // Stable rise on bit 4: latency window and one pulse.
    p0 = pulse_cnt; k = 0;
    raw_in[4] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick_wait(1);
      if (k == 0 && cond_out[4]) k = c;
    end
    chk("bit4_latency_in_window", {31'd0, (k >= 11 && k <= 14)}, 32'd1);
    chk("bit4_single_pulse", pulse_cnt - p0, 32'd1);

    // Short glitch on bit 5 must be rejected.
    p0 = pulse_cnt;
    raw_in[5] = 1'b1;
    tick_wait(3);
    raw_in[5] = 1'b0;
    tick_wait(20);
    chk("glitch_bit5_cond", {31'd0, cond_out[5]}, 32'd0);
    chk("glitch_no_pulse", pulse_cnt - p0, 32'd0);

    // Latched bit 0 stays set after the input drops, then clears.
    raw_in[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick_wait(1);
      hit = cond_out[0];
    end
    chk("latch_set", {31'd0, hit}, 32'd1);
    raw_in[0] = 1'b0;
    tick_wait(20);
    chk("latch_sticky", {31'd0, cond_out[0]}, 32'd1);
    clear_in[0] = 1'b1;
    tick_wait(1);
    clear_in[0] = 1'b0;
    chk("latch_cleared", {31'd0, cond_out[0]}, 32'd0);

    // Clear coinciding with the rise: set wins.
    raw_in[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      if (will_rise0()) begin
        hit = 1'b1;
        clear_in[0] = 1'b1;
        tick_wait(1);
        clear_in[0] = 1'b0;
        chk("set_beats_clear", {31'd0, cond_out[0]}, 32'd1);
      end else tick_wait(1);
    end
    chk("set_clear_coincide_found", {31'd0, hit}, 32'd1);
    raw_in[0] = 1'b0;
    tick_wait(20);
    clear_in[0] = 1'b1;
    tick_wait(1);
    clear_in[0] = 1'b0;

    // Bulk step: every bit updates together with one pulse.
    raw_in = '0;
    do_reset();
    p0 = pulse_cnt; k = 0; first_val = '0;
    raw_in = 32'hFFFF_FFFE;
    for (int c = 1; c <= 20; c++) begin
      tick_wait(1);
      if (k == 0 && cond_out != '0) begin
        k = c;
        first_val = cond_out;
      end
    end
    chk("bulk_first_value", first_val, 32'hFFFF_FFFE);
    chk("bulk_single_pulse", pulse_cnt - p0, 32'd1);
    chk("bulk_final", cond_out, 32'hFFFF_FFFE);

    // Reset mid-debounce discards the partial count.
    raw_in = '0;
    do_reset();
    tick_wait(2);
    raw_in[7] = 1'b1;
    tick_wait(8);
    reset_n = 1'b0;
    #1;
    chk("midreset_cond_out", cond_out, 32'd0);
    chk("midreset_pulse", {31'd0, change_pulse}, 32'd0);
    tick_wait(1);
    reset_n = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick_wait(1);
      if (k == 0 && cond_out[7]) k = c;
    end
    chk("bit7_after_reset_window", {31'd0, (k >= 11 && k <= 14)}, 32'd1);

    // Random phase, scored against the model.
    for (int it = 0; it < 300; it++) begin
      raw_in = raw_in ^ ($urandom & $urandom & $urandom);
      r = $urandom_range(0, 3);
      clear_in = (r == 0) ? $urandom : 32'd0;
      tick_wait(1);
      clear_in = '0;
      tick_wait($urandom_range(0, 23));
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        tick_wait(1);
        reset_n = 1'b1;
      end
    end

    clear_in = '0;
    tick_wait(60);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
